// File: rtl/bw_ctu_clk_pkg.sv
// Shared constants, state encoding and helpers for the CTU clock-divider phase generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bw_ctu_clk_pkg;

   localparam int CNT_W     = 5;
   localparam int MIN_RATIO = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // High-phase length of a divided period: floor(N/2).
   function automatic logic [CNT_W-1:0] half_ratio(input logic [CNT_W-1:0] n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/bw_ctu_clk_div_phase.sv
// Next-phase decode: turns the next cycle index k and ratio N into div0/div1/cyc_start.
// Latency: combinational; the top registers the results.
// Backpressure: none.
//
// Ports:
//   k_nxt      cycle index within the period for the next cycle
//   n_nxt      divide ratio in effect for the next cycle
//   active     divider is running (RUN or DRAIN) next cycle
//   div0_nxt   posedge-phase enable, high for k < floor(N/2)
//   div1_nxt   negedge-phase enable, same as div0 for odd N, low for even N
//   cyc_nxt    first cycle of a divided period
module bw_ctu_clk_div_phase
   import bw_ctu_clk_pkg::*;
(
   input  logic [CNT_W-1:0] k_nxt,
   input  logic [CNT_W-1:0] n_nxt,
   input  logic             active,
   output logic             div0_nxt,
   output logic             div1_nxt,
   output logic             cyc_nxt
);

   logic [CNT_W-1:0] half;
   logic             in_high;

   always_comb begin
      half     = half_ratio(n_nxt);
      in_high  = active && (k_nxt < half);
      div0_nxt = in_high;
      // For odd N the negedge-captured copy stretches the high phase by half a
      // PLL cycle, giving N/2 high time after the sync mux ORs the two phases.
      div1_nxt = in_high && n_nxt[0];
      cyc_nxt  = active && (k_nxt == '0);
   end

endmodule

// File: rtl/bw_ctu_clk_div_gen.sv
// Programmable integer clock-divider phase generator: div0/div1 phase enables, period marker, ratio update handshake.
// Latency: all outputs registered, one cycle after the sampled inputs; a ratio update lands on the next period boundary.
// Backpressure: upd_req is held until ratio_ack; it must be seen low before another request is accepted.
//
// Ports:
//   clk        PLL clock, all state on posedge
//   rst        asynchronous active-high reset
//   en         run the divider (level)
//   div_sync   single-cycle pulse restarting the period (ignored when idle)
//   upd_req    ratio update request (level), div_ratio stable while high
//   div_ratio  requested ratio, clamped up to MIN_RATIO
//   ratio_ack  one-cycle pulse in the first cycle the new ratio is in effect
//   cur_ratio  ratio currently in effect
//   div0/div1  posedge/negedge phase enables for the sync mux
//   cyc_start  first cycle of each divided period
module bw_ctu_clk_div_gen #(
   parameter int CNT_W       = bw_ctu_clk_pkg::CNT_W,
   parameter int MIN_RATIO   = bw_ctu_clk_pkg::MIN_RATIO,
   parameter int RESET_RATIO = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_sync,
   input  logic             upd_req,
   input  logic [CNT_W-1:0] div_ratio,
   output logic             ratio_ack,
   output logic [CNT_W-1:0] cur_ratio,
   output logic             div0,
   output logic             div1,
   output logic             cyc_start
);

   import bw_ctu_clk_pkg::*;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] ratio_nxt;
   logic [CNT_W-1:0] ratio_clamped;
   logic             armed, armed_nxt;
   logic             wrap;
   logic             restart;
   logic             accept;
   logic             div0_nxt, div1_nxt, cyc_nxt;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = '0;
      ratio_clamped = (div_ratio < CNT_W'(MIN_RATIO)) ? CNT_W'(MIN_RATIO) : div_ratio;

      wrap    = (cnt == cur_ratio - CNT_W'(1));
      // A period boundary: natural wrap or a sync restart while the divider runs.
      restart = (state != IDLE) && (wrap || div_sync);
      // Ratio changes only where a fresh period begins, so no runt high phase
      // is ever produced; when idle there is no period to protect.
      accept    = upd_req && armed && ((state == IDLE) || restart);
      ratio_nxt = accept ? ratio_clamped : cur_ratio;
      // Once acked, a still-high request must be seen low before re-arming.
      armed_nxt = accept ? 1'b0 : (upd_req ? armed : 1'b1);

      case (state)
         IDLE: begin
            if (en) state_nxt = RUN;
         end
         RUN: begin
            cnt_nxt = restart ? '0 : cnt + CNT_W'(1);
            if (!en) state_nxt = DRAIN;
         end
         DRAIN: begin
            cnt_nxt = restart ? '0 : cnt + CNT_W'(1);
            if (en)
               state_nxt = RUN;
            else if (wrap && !div_sync)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   bw_ctu_clk_div_phase u_phase (
      .k_nxt    (cnt_nxt),
      .n_nxt    (ratio_nxt),
      .active   (state_nxt != IDLE),
      .div0_nxt (div0_nxt),
      .div1_nxt (div1_nxt),
      .cyc_nxt  (cyc_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cur_ratio <= CNT_W'(RESET_RATIO);
         armed     <= 1'b1;
         ratio_ack <= 1'b0;
         div0      <= 1'b0;
         div1      <= 1'b0;
         cyc_start <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cur_ratio <= ratio_nxt;
         armed     <= armed_nxt;
         ratio_ack <= accept;
         div0      <= div0_nxt;
         div1      <= div1_nxt;
         cyc_start <= cyc_nxt;
      end
   end

endmodule
